video_timing_generator: RTL and testbench

Parametrised raster timing generator: the next generation of the fixed 309×262 sync generator. It produces horizontal and vertical sync, blanking, signed pixel coordinates and an active-area flag from configurable frame geometry. Scroll offsets are frame-locked, and it adds line/frame strobes and a sticky vertical-blank interrupt. It sits between the pixel clock domain root and the video RAM fetch/pixel pipeline.

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/video_timing_generator_timing_axis.sv | 50 +++++
 rtl/video_timing_generator.sv | 126 ++++++++++++
 tb/tb_video_timing_generator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Default frame geometry and width helpers shared by the raster timing generator.
package video_timing_pkg;
  localparam int DEF_H_TOTAL        = 309;
  localparam int DEF_V_TOTAL        = 262;
  localparam int DEF_H_SYNC_LEN     = 23;
  localparam int DEF_V_SYNC_LEN     = 3;
  localparam int DEF_H_ACTIVE_START = 9;
  localparam int DEF_V_ACTIVE_START = 26;
  localparam int DEF_H_ACTIVE       = 256;
  localparam int DEF_V_ACTIVE       = 192;
  localparam int DEF_POS_W          = 10;

  // Smallest signed width whose positive range exceeds every counter value.
  function automatic int min_pos_w(input int h_total, input int v_total);
    int m;
    int w;
    m = (h_total > v_total) ? h_total : v_total;
    w = 31;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << (i - 1)) > m) w = i;
    end
    return w;
  endfunction
endpackage

// File: rtl/video_timing_generator_timing_axis.sv
// One raster axis: enabled wrap counter with sync-window, position and wrap decodes.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int TOTAL        = DEF_H_TOTAL,
  parameter int SYNC_FIRST   = DEF_H_TOTAL - DEF_H_SYNC_LEN,
  parameter int SYNC_LAST    = DEF_H_TOTAL - 1,
  parameter int ACTIVE_START = DEF_H_ACTIVE_START,
  parameter int POS_W        = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [3:0]       offset_i,
  output logic             first_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic [POS_W-1:0] pos_o
);
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST_C = CNT_W'(SYNC_LAST);
  localparam logic [POS_W-1:0] START_C     = POS_W'(ACTIVE_START);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last    = (cnt_q == LAST_C);
  assign wrap_o  = en_i && last;
  assign first_o = (cnt_q == '0);
  // Wraps modulo 2^POS_W, so positions before the active start read as negative.
  assign pos_o   = POS_W'(cnt_q) - START_C - POS_W'(offset_i);

  if (SYNC_FIRST == 0) begin : g_sync_from_zero
    assign sync_o = (cnt_q <= SYNC_LAST_C);
  end else begin : g_sync_window
    localparam logic [CNT_W-1:0] SYNC_FIRST_C = CNT_W'(SYNC_FIRST);
    assign sync_o = (cnt_q >= SYNC_FIRST_C) && (cnt_q <= SYNC_LAST_C);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: two chained axes, frame-locked scroll latches,
// sticky vertical-blank interrupt and a registered output stage.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL          = DEF_H_TOTAL,
  parameter int V_TOTAL          = DEF_V_TOTAL,
  parameter int H_SYNC_LEN       = DEF_H_SYNC_LEN,
  parameter int V_SYNC_LEN       = DEF_V_SYNC_LEN,
  parameter int H_ACTIVE_START   = DEF_H_ACTIVE_START,
  parameter int V_ACTIVE_START   = DEF_V_ACTIVE_START,
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int POS_W            = DEF_POS_W,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       hShift,
  input  logic [3:0]       vShift,
  input  logic             irqAck,
  output logic             hSync,
  output logic             vSync,
  output logic [POS_W-1:0] xPos,
  output logic [POS_W-1:0] yPos,
  output logic             isActive,
  output logic             lineStart,
  output logic             frameStart,
  output logic             vblankIrq
);
  localparam logic             SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [POS_W-1:0] H_ACT_C  = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT_C  = POS_W'(V_ACTIVE);

  if (POS_W < min_pos_w(H_TOTAL, V_TOTAL)) begin : g_chk_pos_w
    $error("POS_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_ACTIVE_START + 15 + H_ACTIVE > H_TOTAL) begin : g_chk_h
    $error("horizontal active window plus maximum shift exceeds H_TOTAL");
  end
  if (V_ACTIVE_START + 15 + V_ACTIVE > V_TOTAL) begin : g_chk_v
    $error("vertical active window plus maximum shift exceeds V_TOTAL");
  end

  logic [3:0]       h_shift_q, v_shift_q;
  logic             h_first, h_wrap, h_sync;
  logic             v_first, v_wrap, v_sync;
  logic [POS_W-1:0] x_pos, y_pos;
  logic             active, irq_set;

  logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             active_q, active_d, line_q, line_d, frame_q, frame_d;
  logic             irq_q, irq_d;

  timing_axis #(
    .TOTAL(H_TOTAL), .SYNC_FIRST(H_TOTAL - H_SYNC_LEN), .SYNC_LAST(H_TOTAL - 1),
    .ACTIVE_START(H_ACTIVE_START), .POS_W(POS_W)
  ) u_h_axis (
    .clk(clk), .reset(reset), .en_i(1'b1), .offset_i(h_shift_q),
    .first_o(h_first), .wrap_o(h_wrap), .sync_o(h_sync), .pos_o(x_pos)
  );

  timing_axis #(
    .TOTAL(V_TOTAL), .SYNC_FIRST(0), .SYNC_LAST(V_SYNC_LEN - 1),
    .ACTIVE_START(V_ACTIVE_START), .POS_W(POS_W)
  ) u_v_axis (
    .clk(clk), .reset(reset), .en_i(h_wrap), .offset_i(v_shift_q),
    .first_o(v_first), .wrap_o(v_wrap), .sync_o(v_sync), .pos_o(y_pos)
  );

  // y == V_ACTIVE is exactly the first line below the shifted active area.
  assign irq_set = h_first && (y_pos == V_ACT_C);
  assign active  = !x_pos[POS_W-1] && (x_pos < H_ACT_C) &&
                   !y_pos[POS_W-1] && (y_pos < V_ACT_C);

  always_comb begin
    h_sync_d = SYNC_ON ? h_sync : ~h_sync;
    v_sync_d = SYNC_ON ? v_sync : ~v_sync;
    x_d      = x_pos;
    y_d      = y_pos;
    active_d = active;
    line_d   = h_first;
    frame_d  = h_first && v_first;
    irq_d    = irq_q;
    if (irq_set)     irq_d = 1'b1;
    else if (irqAck) irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_shift_q <= hShift;
      v_shift_q <= vShift;
      h_sync_q  <= ~SYNC_ON;
      v_sync_q  <= ~SYNC_ON;
      x_q       <= '0;
      y_q       <= '0;
      active_q  <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (v_wrap) begin
        h_shift_q <= hShift;
        v_shift_q <= vShift;
      end
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      irq_q    <= irq_d;
    end
  end

  assign hSync      = h_sync_q;
  assign vSync      = v_sync_q;
  assign xPos       = x_q;
  assign yPos       = y_q;
  assign isActive   = active_q;
  assign lineStart  = line_q;
  assign frameStart = frame_q;
  assign vblankIrq  = irq_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboarded bench: active-high-sync instance runs a frame and a bit; an
// active-low-sync instance runs alongside and takes a mid-frame reset pulse.
module tb_video_timing_generator;
  localparam int HT = 309;
  localparam int VT = 262;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, ack_a, ack_b;
  logic [3:0] hs_a, vs_a, hs_b, vs_b;
  logic       a_hs, a_vs, a_act, a_ls, a_fs, a_irq;
  logic       b_hs, b_vs, b_act, b_ls, b_fs, b_irq;
  logic [9:0] a_x, a_y, b_x, b_y;

  video_timing_generator u_dut_a (
    .clk(clk), .reset(rst_a), .hShift(hs_a), .vShift(vs_a), .irqAck(ack_a),
    .hSync(a_hs), .vSync(a_vs), .xPos(a_x), .yPos(a_y), .isActive(a_act),
    .lineStart(a_ls), .frameStart(a_fs), .vblankIrq(a_irq)
  );

  video_timing_generator #(.SYNC_ACTIVE_HIGH(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .hShift(hs_b), .vShift(vs_b), .irqAck(ack_b),
    .hSync(b_hs), .vSync(b_vs), .xPos(b_x), .yPos(b_y), .isActive(b_act),
    .lineStart(b_ls), .frameStart(b_fs), .vblankIrq(b_irq)
  );

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       ls;
    logic       fs;
    logic       irq;
  } out_t;

  typedef struct {
    out_t exp;
    int   col;
    int   line;
    int   frame;
    bit   rst;
  } entry_t;

  entry_t q_a[$];
  entry_t q_b[$];

  int col_a, line_a, frame_a, mhs_a, mvs_a;
  int col_b, line_b, frame_b, mhs_b, mvs_b;
  bit irq_a, irq_b;
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int fs_prev = -1;

  function automatic out_t decode(int col, int line, int hs, int vs, bit pol);
    out_t o;
    int   x, y;
    bit   hsy, vsy;
    x = col - 9 - hs;
    y = line - 26 - vs;
    hsy = (col >= HT - 23);
    vsy = (line < 3);
    o.hsync  = pol ? hsy : !hsy;
    o.vsync  = pol ? vsy : !vsy;
    o.x      = 10'(x);
    o.y      = 10'(y);
    o.active = (x >= 0) && (x < 256) && (y >= 0) && (y < 192);
    o.ls     = (col == 0);
    o.fs     = (col == 0) && (line == 0);
    o.irq    = 1'b0;
    return o;
  endfunction

  function automatic out_t reset_val(bit pol);
    out_t o;
    o = '0;
    o.hsync = !pol;
    o.vsync = !pol;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit rst, input bit pol, input logic [3:0] hsin,
                            input logic [3:0] vsin, input bit ack,
                            inout int col, inout int line, inout int frame,
                            inout int mhs, inout int mvs, inout bit irq,
                            output entry_t e);
    e.col = col; e.line = line; e.frame = frame; e.rst = rst;
    if (rst) begin
      e.exp = reset_val(pol);
      col = 0; line = 0; frame = 0;
      mhs = int'(hsin); mvs = int'(vsin);
      irq = 1'b0;
    end else begin
      e.exp = decode(col, line, mhs, mvs, pol);
      if (col == 0 && line == 26 + mvs + 192) irq = 1'b1;
      else if (ack) irq = 1'b0;
      e.exp.irq = irq;
      if (col == HT - 1 && line == VT - 1) begin
        mhs = int'(hsin); mvs = int'(vsin);
      end
      col++;
      if (col == HT) begin
        col = 0; line++;
        if (line == VT) begin line = 0; frame++; end
      end
    end
  endtask

  task automatic directed(input entry_t pa, input out_t oa, input entry_t pb, input out_t ob);
    if (!pa.rst) begin
      if (oa.fs) begin
        if (fs_prev >= 0) check("fs_period", cyc - fs_prev, 80958);
        fs_prev = cyc;
      end
      if (pa.frame == 0) begin
        if (pa.col == 0 && pa.line == 0) begin
          check("a_first_fs", oa.fs, 1); check("a_first_ls", oa.ls, 1);
          check("a_first_vs", oa.vsync, 1);
          check("a_first_x", oa.x, 10'h3F7); check("a_first_y", oa.y, 10'h3E6);
        end
        if (pa.line == 5 && pa.col == 285) check("a_hs_pre", oa.hsync, 0);
        if (pa.line == 5 && pa.col == 286) check("a_hs_start", oa.hsync, 1);
        if (pa.line == 5 && pa.col == 308) check("a_hs_end", oa.hsync, 1);
        if (pa.line == 2 && pa.col == 0) check("a_vs_l2", oa.vsync, 1);
        if (pa.line == 3 && pa.col == 0) check("a_vs_l3", oa.vsync, 0);
        if (pa.line == 26 && pa.col == 8) begin
          check("a_x_m1", oa.x, 10'h3FF); check("a_act_c8", oa.active, 0);
        end
        if (pa.line == 26 && pa.col == 9) begin
          check("a_act_first", oa.active, 1);
          check("a_x0", oa.x, 0); check("a_y0", oa.y, 0);
        end
        if (pa.line == 217 && pa.col == 264) begin
          check("a_act_last", oa.active, 1);
          check("a_x255", oa.x, 255); check("a_y191", oa.y, 191);
        end
        if (pa.line == 217 && pa.col == 265) check("a_act_after", oa.active, 0);
        if (pa.line == 150 && pa.col == 9) check("a_x_noshift", oa.x, 0);
        if (pa.line == 217 && pa.col == 308) check("a_irq_pre", oa.irq, 0);
        if (pa.line == 218 && pa.col == 0) check("a_irq_set", oa.irq, 1);
        if (pa.line == 218 && pa.col == 1) check("a_irq_clr", oa.irq, 0);
      end
      if (pa.frame == 1 && pa.line == 0) begin
        if (pa.col == 0)  check("a_f1_x", oa.x, 10'h3F2);
        if (pa.col == 13) check("a_f1_xm1", oa.x, 10'h3FF);
        if (pa.col == 14) check("a_f1_x0", oa.x, 0);
      end
    end
    if (pb.rst) begin
      check("b_rst_hs", ob.hsync, 1); check("b_rst_vs", ob.vsync, 1);
      check("b_rst_fs", ob.fs, 0); check("b_rst_x", ob.x, 0);
    end else if (pb.frame == 0) begin
      if (pb.col == 0 && pb.line == 0) begin
        check("b_first_fs", ob.fs, 1); check("b_first_vs", ob.vsync, 0);
        check("b_first_hs", ob.hsync, 1);
        check("b_first_x", ob.x, 10'h3F7); check("b_first_y", ob.y, 10'h3E6);
      end
      if (pb.line == 5 && pb.col == 285) check("b_hs_pre", ob.hsync, 1);
      if (pb.line == 5 && pb.col == 286) check("b_hs_on", ob.hsync, 0);
      if (pb.line == 3 && pb.col == 0)   check("b_vs_l3", ob.vsync, 1);
    end
  endtask

  task automatic step();
    entry_t ea, eb, pa, pb;
    out_t   oa, ob;
    model_step(rst_a, 1'b1, hs_a, vs_a, ack_a, col_a, line_a, frame_a, mhs_a, mvs_a, irq_a, ea);
    model_step(rst_b, 1'b0, hs_b, vs_b, ack_b, col_b, line_b, frame_b, mhs_b, mvs_b, irq_b, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    cyc++;
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    oa = {a_hs, a_vs, a_x, a_y, a_act, a_ls, a_fs, a_irq};
    ob = {b_hs, b_vs, b_x, b_y, b_act, b_ls, b_fs, b_irq};
    check("a_out", 32'(oa), 32'(pa.exp));
    check("b_out", 32'(ob), 32'(pb.exp));
    directed(pa, oa, pb, ob);
  endtask

  task automatic run_until(input int f, input int c, input int l);
    int n;
    n = 0;
    while (!(frame_a == f && col_a == c && line_a == l)) begin
      if (n > 90000) begin
        checks++;
        fails++;
        $display("FAIL run_until: position (%0d,%0d,%0d) not reached", f, c, l);
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    hs_a = 4'd0; vs_a = 4'd0; hs_b = 4'd0; vs_b = 4'd0;
    col_a = 0; line_a = 0; frame_a = 0; mhs_a = 0; mvs_a = 0; irq_a = 1'b0;
    col_b = 0; line_b = 0; frame_b = 0; mhs_b = 0; mvs_b = 0; irq_b = 1'b0;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0;

    // Ack while the irq is clear must have no effect.
    run_until(0, 100, 10);
    ack_a = 1'b1; step(); ack_a = 1'b0;

    // Mid-frame scroll change: held off until the next frame.
    run_until(0, 0, 100);
    hs_a = 4'd5; step();

    run_until(0, 200, 150);
    rst_b = 1'b1; step(); rst_b = 1'b0;

    // Ack coinciding with the set keeps the irq; the next ack clears it.
    run_until(0, 0, 218);
    ack_a = 1'b1; step(); step(); ack_a = 1'b0;

    run_until(1, 20, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
